i2c_slave_ctrl: RTL and testbench

Bit-level sequencer for the I2C slave: detects START/STOP, shifts in the 7-bit device address and R/W bit, runs address/data ACK phases, and bridges transfers to a simple register-file port with an auto-incrementing pointer. It sits between the synchronized pad signals and the slave's register bank. It is the only block that drives the SDA open-drain enable.

---
 rtl/i2c_slave_ctrl_if.sv | 23 ++
 rtl/i2c_slave_ctrl.sv | 179 +++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_ctrl_if.sv
// Pad and register-bank signals of the I2C slave sequencer.
// The slave modport is the sequencer's side. The master modport is the pad/bank side.
interface i2c_slave_ctrl_if #(parameter int ADDR_W = 8);
  logic              scl_i;
  logic              sda_i;
  logic              sda_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave bit sequencer: START/STOP decode, address match, ACK phases, and a
// register-file bridge with an auto-incrementing pointer.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_W     = 8
) (
  input logic              clk,
  input logic              rst,
  i2c_slave_ctrl_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        scl_pipe_q, sda_pipe_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rw_q, rw_d;
  logic              phase_q, phase_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d, re_q, re_d, cap_q;

  // [0],[1] synchronize; [1] is the current sample, [2] the history.
  logic scl_s, scl_h, sda_s, sda_h;
  assign scl_s = scl_pipe_q[1];
  assign scl_h = scl_pipe_q[2];
  assign sda_s = sda_pipe_q[1];
  assign sda_h = sda_pipe_q[2];

  logic rise, fall, start, stop;
  assign rise  = ~scl_h &  scl_s;
  assign fall  =  scl_h & ~scl_s;
  assign start =  scl_h &  scl_s &  sda_h & ~sda_s;
  assign stop  =  scl_h &  scl_s & ~sda_h &  sda_s;

  logic [7:0] rx_byte;
  assign rx_byte = {shift_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      scl_pipe_q <= {scl_pipe_q[1:0], bus.scl_i};
      sda_pipe_q <= {sda_pipe_q[1:0], bus.sda_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      oe_q       <= oe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cap_q      <= re_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    phase_d = phase_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    if (cap_q) shift_d = bus.reg_rdata;
    // Pointer advances the cycle after the write strobe, so the strobe sees the old address.
    if (we_q)  addr_d  = addr_q + ADDR_W'(1);
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: if (rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          phase_d = 1'b0;
          if (cnt_q == 3'd7) begin
            if (state_q == ADDR) begin
              rw_d    = rx_byte[0];
              state_d = (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
            end else if (state_q == PTR) begin
              addr_d  = ADDR_W'(rx_byte);
              state_d = PTR_ACK;
            end else begin
              wdata_d = rx_byte;
              we_d    = 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end
        // First fall pulls SDA for the ACK bit, second fall ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (rise && phase_q && state_q == ADDR_ACK && rw_q) re_d = 1'b1;
          if (fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              cnt_d   = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                oe_d    = ~shift_q[7];
                state_d = RDATA;
              end else begin
                oe_d    = 1'b0;
                state_d = (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (rise) cnt_d = cnt_q + 3'd1;
          if (fall) begin
            if (cnt_q == 3'd0) begin
              oe_d    = 1'b0;
              phase_d = 1'b0;
              state_d = RDATA_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RDATA_ACK: begin
          if (rise) begin
            addr_d = addr_q + ADDR_W'(1);
            if (!sda_s) begin
              phase_d = 1'b1;
              re_d    = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
          if (fall && phase_q) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            oe_d    = ~shift_q[7];
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-level I2C master on an open-drain SDA line,
// and a register model that answers reads one cycle after reg_re.
module tb_i2c_slave_ctrl;
  localparam int HP = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic mon_clr = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] mem [256];
  int         we_cnt, re_cnt, oe_cnt, both_cnt;
  logic [7:0] wa0, wd0, wa1, wd1;

  i2c_slave_ctrl_if #(.ADDR_W(8)) bus ();

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h50), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  always @(posedge clk) begin
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      we_cnt <= 0; re_cnt <= 0; oe_cnt <= 0; both_cnt <= 0;
      wa0 <= '0; wd0 <= '0; wa1 <= '0; wd1 <= '0;
    end else begin
      if (bus.reg_we) begin
        if (we_cnt == 0) begin wa0 <= bus.reg_addr; wd0 <= bus.reg_wdata; end
        else begin wa1 <= bus.reg_addr; wd1 <= bus.reg_wdata; end
        we_cnt <= we_cnt + 1;
      end
      if (bus.reg_re) re_cnt <= re_cnt + 1;
      if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
      if (bus.reg_we && bus.reg_re) both_cnt <= both_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; wait_clk(1); mon_clr = 1'b0;
  endtask

  // One SCL clock: drive b during low, return the line value mid-high.
  task automatic bit_xfer(input logic b, output logic v);
    wait_clk(3); sda_m = b;
    wait_clk(HP); scl_m = 1'b1;
    wait_clk(HP / 2); v = bus.sda_i;
    wait_clk(HP / 2); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wait_clk(HP); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clk(3); sda_m = 1'b1;
    wait_clk(HP); scl_m = 1'b1;
    wait_clk(HP); sda_m = 1'b0;
    wait_clk(HP); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(3); sda_m = 1'b0;
    wait_clk(HP); scl_m = 1'b1;
    wait_clk(HP); sda_m = 1'b1;
    wait_clk(HP);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic v;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], v);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, v);
      b[i] = v;
    end
    bit_xfer(nack, v);
  endtask

  initial begin
    logic       ack;
    logic       v;
    logic [7:0] rd;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;
    mem[8'h20] = 8'h0F;
    mon_clr = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    mon_clr = 1'b0;
    wait_clk(2);

    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_reg_addr", bus.reg_addr, 0);
    chk("rst_reg_wdata", bus.reg_wdata, 0);
    chk("rst_strobes", {bus.reg_we, bus.reg_re}, 0);
    chk("rst_busy", bus.busy, 0);

    // Write two bytes starting at 0x10
    i2c_start();
    chk("wr_busy", bus.busy, 1);
    send_byte(8'hA0, ack); chk("wr_ack_addr", ack, 0);
    send_byte(8'h10, ack); chk("wr_ack_ptr", ack, 0);
    send_byte(8'h5A, ack); chk("wr_ack_d0", ack, 0);
    send_byte(8'hC3, ack); chk("wr_ack_d1", ack, 0);
    i2c_stop();
    chk("wr_we_cnt", we_cnt, 2);
    chk("wr_a0", wa0, 8'h10);
    chk("wr_d0", wd0, 8'h5A);
    chk("wr_a1", wa1, 8'h11);
    chk("wr_d1", wd1, 8'hC3);
    chk("wr_wdata", bus.reg_wdata, 8'hC3);
    chk("wr_final_addr", bus.reg_addr, 8'h12);
    chk("wr_busy_end", bus.busy, 0);

    // Random read of 0x10, 0x11
    clr_mon();
    i2c_start();
    send_byte(8'hA0, ack); chk("rd_ack_waddr", ack, 0);
    send_byte(8'h10, ack); chk("rd_ack_ptr", ack, 0);
    i2c_rstart();
    send_byte(8'hA1, ack); chk("rd_ack_raddr", ack, 0);
    recv_byte(1'b0, rd); chk("rd_byte0", rd, 8'h5A);
    recv_byte(1'b1, rd); chk("rd_byte1", rd, 8'hC3);
    chk("rd_idle_after_nack", bus.busy, 0);
    i2c_stop();
    chk("rd_re_cnt", re_cnt, 2);
    chk("rd_we_cnt", we_cnt, 0);
    chk("rd_final_addr", bus.reg_addr, 8'h12);

    // Address mismatch
    clr_mon();
    i2c_start();
    send_byte(8'hA2, ack); chk("nm_nack", ack, 1);
    chk("nm_busy", bus.busy, 0);
    send_byte(8'h55, ack);
    i2c_stop();
    chk("nm_oe_cnt", oe_cnt, 0);
    chk("nm_strobes", we_cnt + re_cnt, 0);

    // Pointer wrap
    clr_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack); chk("wrap_ack", ack, 0);
    i2c_stop();
    chk("wrap_a0", wa0, 8'hFF);
    chk("wrap_d0", wd0, 8'h11);
    chk("wrap_a1", wa1, 8'h00);
    chk("wrap_d1", wd1, 8'h22);
    chk("wrap_addr", bus.reg_addr, 8'h01);

    // Abort after 4 data bits, then a normal write
    clr_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, v);
    i2c_stop();
    chk("abort_we_cnt", we_cnt, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_addr", bus.reg_addr, 8'h30);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    send_byte(8'h77, ack); chk("post_abort_ack", ack, 0);
    i2c_stop();
    chk("post_abort_we", we_cnt, 1);
    chk("post_abort_a0", wa0, 8'h40);
    chk("post_abort_d0", wd0, 8'h77);
    chk("post_abort_addr", bus.reg_addr, 8'h41);

    // Reset while the slave drives a 0 data bit
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack);
    i2c_rstart();
    send_byte(8'hA1, ack);
    wait_clk(6);
    chk("mid_rd_drive", bus.sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    chk("mid_rst_oe", bus.sda_oe, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_addr", bus.reg_addr, 0);
    i2c_stop();
    chk("no_dual_strobe", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
